// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_pkg;

    // Request FSM states of the fetch unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // Instruction shown to decode when nothing has been fetched.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default first fetch address after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: return address of the instruction and the word itself.
    typedef struct packed {
        logic [31:0] pc_plus;
        logic [31:0] instr;
    } fetch_entry_t;

    // Forces an address onto a word boundary by clearing the two byte-offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched instructions between the memory port and decode.
// Flush empties the buffer in one cycle; the head reads as zero when empty.
module fetch_fifo
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    // Qualify pop against an empty buffer and push against a full one that is not draining.
    always_comb begin
        if (count_r != 2'd0) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
        if ((count_r != 2'd2) || pop_ok_s) begin
            push_ok_s = push;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy; flush wins over any simultaneous push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head of the buffer, forced to zero while empty so stale entries never leak out.
    always_comb begin
        if (count_r != 2'd0) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: fetch PC, single-outstanding memory request FSM and
// a two-entry instruction buffer feeding decode. Redirects from decode flush
// the buffer and squash any in-flight fetch.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        PCSrcD,
    input  logic        jumpD,
    input  logic [31:0] pcchangeD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] irD,
    output logic [31:0] pcplusD,
    output logic        validD
);

    localparam logic [2:0] FIFO_FULL = 3'(FIFO_DEPTH);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic [1:0]   fifo_count_s;
    fetch_entry_t head_s;
    fetch_entry_t push_entry_s;
    logic         valid_s;
    logic         pop_s;
    logic         redirect_s;
    logic         outstanding_s;
    logic         room_s;
    logic         req_s;
    logic         push_s;

    // Decode-side handshake: consume the head when valid and not stalled; a branch
    // or jump only counts as a redirect when its own instruction is consumed.
    always_comb begin
        valid_s = (fifo_count_s != 2'd0);
        pop_s   = valid_s && !stallD;
        if (pop_s && (PCSrcD || jumpD)) begin
            redirect_s = 1'b1;
        end else begin
            redirect_s = 1'b0;
        end
    end

    // A new request is allowed only while buffered plus in-flight entries leave a free slot.
    always_comb begin
        if ((state_r == ST_WAIT) || (state_r == ST_DROP)) begin
            outstanding_s = 1'b1;
        end else begin
            outstanding_s = 1'b0;
        end
        room_s = (({1'b0, fifo_count_s} + {2'b00, outstanding_s}) < FIFO_FULL);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
                if (req_s && imem_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                // Returning data ends the wait whether it is kept or squashed.
                if (imem_rvalid) begin
                    state_nxt_s = ST_REQ;
                end else if (redirect_s) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request strobe and buffer push. A redirect suppresses both so
    // neither a wrong-path request nor wrong-path data is ever committed.
    always_comb begin
        req_s  = 1'b0;
        push_s = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (room_s && !redirect_s) begin
                    req_s = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid && !redirect_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                req_s  = 1'b0;
                push_s = 1'b0;
            end
        endcase
    end

    // Next fetch PC: redirect target has priority, otherwise advance after a kept fetch.
    always_comb begin
        if (redirect_s) begin
            pc_nxt_s = align_word(pcchangeD);
        end else if (push_s) begin
            pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    assign push_entry_s = {pc_r + 32'd4, imem_rdata};

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect_s),
        .push_data (push_entry_s),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    // Decode-facing view of the buffer head; a nop with zero return address when empty.
    always_comb begin
        if (valid_s) begin
            irD     = head_s.instr;
            pcplusD = head_s.pc_plus;
        end else begin
            irD     = NOP_INSTR;
            pcplusD = 32'h0000_0000;
        end
    end

    assign validD    = valid_s;
    assign imem_req  = req_s;
    assign imem_addr = pc_r;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch. The reference model works at the
// level of program order: the next instruction decode must see is either the
// sequential successor or the redirect target of the one just consumed.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        PCSrcD;
    logic        jumpD;
    logic [31:0] pcchangeD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] irD;
    logic [31:0] pcplusD;
    logic        validD;

    if_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallD      (stallD),
        .PCSrcD      (PCSrcD),
        .jumpD       (jumpD),
        .pcchangeD   (pcchangeD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .irD         (irD),
        .pcplusD     (pcplusD),
        .validD      (validD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcplus;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // Model state (driver process only).
    logic [31:0] cur_pc;
    logic [31:0] exp_fetch;
    int          occ;
    bit          pend_valid;
    bit          pend_live;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          consumed;
    int          ready_pct, stall_pct, redir_pct, lat_min, lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_next(input logic [31:0] pc);
        exp_t e;
        e.pcplus = pc + 32'd4;
        e.instr  = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        cur_pc     = RST_PC;
        exp_fetch  = RST_PC;
        occ        = 0;
        pend_valid = 1'b0;
        pend_live  = 1'b0;
        exp_q.delete();
        expect_next(RST_PC);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(4, 0))
            0:       t = 32'h0000_0100;
            1:       t = 32'h0000_0040;
            2:       t = 32'hFFFF_FFF8;
            3:       t = $urandom & 32'h0000_0FFF;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    task automatic check_reset_outputs();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_validD", {31'd0, validD}, 32'd0);
        check("rst_irD", irD, 32'h0000_0000);
        check("rst_pcplusD", pcplusD, 32'h0000_0000);
    endtask

    // One clock of stimulus: memory model, decode model, and the scoreboard pushes.
    task automatic step();
        bit          deliver, acc, cons, redir;
        int          occ_before;
        logic [31:0] nxt, tgt;
        @(negedge clk);
        deliver = 1'b0;
        if (pend_valid) begin
            if (pend_cnt == 0) deliver = 1'b1;
            else pend_cnt--;
        end
        imem_rvalid = deliver;
        imem_rdata  = deliver ? mem_word(pend_addr) : $urandom;
        imem_ready  = ($urandom_range(99, 0) < ready_pct);
        stallD      = ($urandom_range(99, 0) < stall_pct);
        PCSrcD      = ($urandom_range(99, 0) < redir_pct);
        jumpD       = ($urandom_range(99, 0) < redir_pct);
        pcchangeD   = pick_target();
        #1;
        acc        = imem_req && imem_ready;
        cons       = validD && !stallD;
        redir      = cons && (PCSrcD || jumpD);
        tgt        = pcchangeD & 32'hFFFF_FFFC;
        occ_before = occ;
        if (occ_before >= 2) check("req_when_full", {31'd0, imem_req}, 32'd0);
        if (deliver) begin
            pend_valid = 1'b0;
            if (pend_live && !redir) occ++;
        end
        if (cons) begin
            consumed++;
            occ--;
            nxt    = redir ? tgt : cur_pc + 32'd4;
            cur_pc = nxt;
            expect_next(nxt);
        end
        if (redir) begin
            occ       = 0;
            pend_live = 1'b0;
            exp_fetch = tgt;
        end
        if (acc) begin
            check("fetch_addr", imem_addr, exp_fetch);
            check("one_outstanding", {31'd0, pend_valid}, 32'd0);
            check("fifo_room", {31'd0, occ_before < 2}, 32'd1);
            pend_valid = 1'b1;
            pend_live  = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = $urandom_range(lat_max - 1, lat_min - 1);
            exp_fetch  = exp_fetch + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares whatever decode sees against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (validD) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", 32'd1, 32'd0);
                    end else begin
                        check("irD", irD, exp_q[0].instr);
                        check("pcplusD", pcplusD, exp_q[0].pcplus);
                        if (!stallD) void'(exp_q.pop_front());
                    end
                end else begin
                    check("empty_irD_nop", irD, 32'h0000_0000);
                end
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1; stallD = 1'b0; PCSrcD = 1'b0; jumpD = 1'b0; pcchangeD = 32'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        consumed = 0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Sequential stream, always-ready memory with one-cycle latency.
        ready_pct = 100; stall_pct = 0; redir_pct = 0; lat_min = 1; lat_max = 1;
        run(20);
        // Decode stalled long enough for the buffer to fill, then released.
        stall_pct = 100; run(8);
        stall_pct = 0;   run(12);
        // Fully random traffic with redirects, stalls and up to 3-cycle latency.
        ready_pct = 70; stall_pct = 25; redir_pct = 15; lat_min = 1; lat_max = 3;
        run(600);

        // Reset in the middle of a 3-cycle memory wait, stale data after release.
        ready_pct = 100; stall_pct = 0; redir_pct = 0; lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (pend_valid && pend_cnt >= 1) found = 1'b1;
        end
        check("wait_before_reset", {31'd0, found}, 32'd1);
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1; imem_rvalid = 1'b0; stallD = 1'b0; PCSrcD = 1'b0; jumpD = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_ready = 1'b1;
        model_reset();
        mon_en = 1'b1;
        #1;
        check("idle_no_req", {31'd0, imem_req}, 32'd0);

        ready_pct = 80; stall_pct = 20; redir_pct = 10; lat_min = 1; lat_max = 2;
        run(200);

        check("progress", {31'd0, consumed >= 100}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, 2, number of fetched-instruction buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stallD  input  1  decode stage holds its current instruction.
REQ-006 PCSrcD  input  1  taken branch from decode.
REQ-007 jumpD  input  1  j/jr from decode.
REQ-008 pcchangeD  input  32  redirect target.
REQ-009 imem_req  output  1  fetch request valid.
REQ-010 imem_addr  output  32  word-aligned fetch address.
REQ-011 imem_ready  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  input  1  read data valid.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 irD  output  32  instruction presented to decode.
REQ-015 pcplusD  output  32  fetch PC + 4 of irD.
REQ-016 validD  output  1  irD/pcplusD are valid.

Function
REQ-017 The block SHALL hold a fetch PC register, a request FSM and a 2-entry FIFO of {pc+4, instr}.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT and DROP.
REQ-019 IDLE: the block SHALL move to REQ on the first cycle after reset release.
REQ-020 REQ: imem_req SHALL be 1 and imem_addr SHALL equal the PC only when FIFO count + outstanding < 2; otherwise imem_req SHALL be 0.
REQ-021 REQ to WAIT SHALL occur on imem_req && imem_ready.
REQ-022 WAIT: on imem_rvalid, {PC+4, imem_rdata} SHALL be pushed, PC SHALL become PC+4, and the FSM SHALL return to REQ; at most one request SHALL be outstanding.
REQ-023 Dequeue SHALL occur when validD && !stallD.
REQ-024 irD/pcplusD SHALL show the FIFO head combinationally.
REQ-025 When the FIFO is empty, validD SHALL be 0 and irD SHALL be 32'h0000_0000 (nop).
REQ-026 Redirect SHALL be defined as (PCSrcD | jumpD) && validD && !stallD; the head, which is the branch, is dequeued normally.
REQ-027 On redirect, all remaining FIFO entries SHALL be flushed, PC SHALL be loaded with pcchangeD[31:2],2'b00, and no delay slot SHALL be executed.
REQ-028 Redirect in REQ SHALL drop any unaccepted request and the next cycle SHALL request pcchangeD; imem_req may deassert for that cycle.
REQ-029 Redirect in WAIT SHALL move the FSM to DROP.
REQ-030 DROP: the returning imem_rvalid data SHALL be discarded without a push, then the FSM SHALL go to REQ at the new PC.
REQ-031 Redirect coinciding with imem_rvalid in WAIT SHALL discard that data and go directly to REQ.
REQ-032 Redirect while stallD=1 SHALL be ignored; decode re-asserts it after the stall.
REQ-033 Push and pop in the same cycle SHALL leave the count unchanged; push to a full FIFO is unreachable by REQ-020.
REQ-034 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-035 Latency SHALL be: request accepted in cycle N, rvalid in cycle N+k, validD=1 in cycle N+k+1.

Reset
REQ-036 While rst=1: PC=RESET_PC, FSM=IDLE, FIFO empty, imem_req=0, imem_addr=RESET_PC, validD=0, irD=0, pcplusD=0.
REQ-037 rst asserted mid-transaction SHALL abandon the request.
REQ-038 An imem_rvalid arriving after reset release for a request abandoned by reset SHALL be ignored, since the FSM is not in WAIT.

Structure
REQ-039 A shared package SHALL hold the FSM state typedef, NOP_INSTR=32'h0, and the RESET_PC default.
REQ-040 The FIFO SHALL be a sub-module fetch_fifo, 2 entries x 64 bits, with push/pop/flush/count/head.

Verification
REQ-041 Reset release, imem_ready=1, rvalid 1 cycle after accept -> imem_addr 0x0, 0x4, 0x8 in order; irD follows memory; pcplusD 0x4, 0x8, 0xC.
REQ-042 stallD=1 for 5 cycles with the FIFO filling -> at most 2 entries and imem_req=0 when full; order preserved after release, none lost or duplicated.
REQ-043 Redirect (jumpD=1, pcchangeD=0x100) while the FIFO holds 0x8 and 0xC -> both flushed; next imem_addr=0x100; next validD instruction has pcplusD=0x104.
REQ-044 PCSrcD=1, pcchangeD=0x40 while in WAIT with 3-cycle memory latency -> stale rdata is not pushed; next request is to 0x40.
REQ-045 PCSrcD=1 with stallD=1 -> no flush and PC unchanged; with stallD=0 the following cycle, redirect is taken.
REQ-046 rst pulsed while in WAIT with rvalid arriving after release -> outputs return to reset values, stale data is ignored, fetch restarts at RESET_PC.
